// File: rtl/if_fetch_ctl_if.sv
//==============================================================================
// Module   : if_fetch_ctl_if
// Brief    : preIF / instruction-memory / IF-stage signal bundle for if_fetch_ctl
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface if_fetch_ctl_if #(
  parameter int DATA_W = 64
);
  logic              preif_req_i;
  logic [31:0]       preif_pc_i;
  logic              preif_addr_ok_o;
  logic              inst_req_o;
  logic [31:0]       inst_addr_o;
  logic              inst_addr_ok_i;
  logic              inst_data_ok_i;
  logic [DATA_W-1:0] inst_rdata_i;
  logic              if_valid_i;
  logic              if_no_req_i;
  logic              id_allowin_i;
  logic              flush_i;
  logic              if_ready_go_o;
  logic [DATA_W-1:0] if_inst_o;
  logic [1:0]        outst_cnt_o;

  // Fetch controller side
  modport master (
    input  preif_req_i, preif_pc_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
           if_valid_i, if_no_req_i, id_allowin_i, flush_i,
    output preif_addr_ok_o, inst_req_o, inst_addr_o, if_ready_go_o, if_inst_o,
           outst_cnt_o
  );

  // Surrounding pipeline / memory side
  modport slave (
    output preif_req_i, preif_pc_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
           if_valid_i, if_no_req_i, id_allowin_i, flush_i,
    input  preif_addr_ok_o, inst_req_o, inst_addr_o, if_ready_go_o, if_inst_o,
           outst_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_ctl.sv
//==============================================================================
// Module   : if_fetch_ctl
// Brief    : Instruction-fetch request controller with outstanding tracking,
//            flush discard of in-flight responses and a one-entry data buffer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_fetch_ctl #(
  parameter int MAX_OUTST = 2,
  parameter int DATA_W    = 64
) (
  input  wire logic     clk,
  input  wire logic     rst,
  if_fetch_ctl_if.master bus
);

  localparam logic [1:0] C_MAX_OUTST = 2'(MAX_OUTST);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_addr;
  logic [1:0]        r_outst;
  logic [1:0]        r_discard;
  logic              r_flush_pend;
  logic              r_buf_valid;
  logic [DATA_W-1:0] r_buf_data;

  logic              w_issue;
  logic              w_req;
  logic [31:0]       w_addr;
  logic              w_accept;
  logic              w_data_acc;
  logic              w_drop;
  logic              w_consume;
  logic              w_ready_go;

  //--------------------------------------------------------------------------
  // Request FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_req       = 1'b0;
    w_addr      = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.preif_req_i && !bus.flush_i && (r_outst < C_MAX_OUTST) && !r_buf_valid) begin
          w_issue = 1'b1;
          w_req   = 1'b1;
          w_addr  = bus.preif_pc_i;
          if (!bus.inst_addr_ok_i) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A request already on the bus must stay stable until accepted, even across a flush
        w_req  = 1'b1;
        w_addr = r_addr;
        if (bus.inst_addr_ok_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept   = w_req & bus.inst_addr_ok_i;
  assign w_data_acc = bus.inst_data_ok_i & (r_discard == 2'd0);
  assign w_drop     = bus.inst_data_ok_i & (r_discard != 2'd0);
  assign w_consume  = bus.if_valid_i & bus.id_allowin_i;
  assign w_ready_go = bus.if_valid_i & ~bus.flush_i
                    & (bus.if_no_req_i | r_buf_valid | w_data_acc);

  //--------------------------------------------------------------------------
  // Held address, outstanding and discard bookkeeping
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= 32'd0;
      r_outst      <= 2'd0;
      r_discard    <= 2'd0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_issue && !bus.inst_addr_ok_i) begin
        r_addr <= bus.preif_pc_i;
      end

      r_outst <= r_outst + {1'b0, w_accept} - {1'b0, bus.inst_data_ok_i};

      if ((r_state == S_HOLD) && w_accept) begin
        r_flush_pend <= 1'b0;
      end else if ((r_state == S_HOLD) && bus.flush_i) begin
        r_flush_pend <= 1'b1;
      end

      // Everything in flight at the flush, including a same-cycle acceptance, is stale
      if (bus.flush_i) begin
        r_discard <= r_outst - {1'b0, bus.inst_data_ok_i} + {1'b0, w_accept};
      end else begin
        r_discard <= r_discard - {1'b0, w_drop} + {1'b0, w_accept & r_flush_pend};
      end
    end
  end

  //--------------------------------------------------------------------------
  // One-entry response buffer
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else begin
      if (bus.flush_i) begin
        r_buf_valid <= 1'b0;
      end else if (w_data_acc && !w_consume) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= bus.inst_rdata_i;
      end else if (w_consume && w_ready_go) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs are forced low while reset is held, independent of the inputs
  //--------------------------------------------------------------------------
  assign bus.inst_req_o      = w_req & ~rst;
  assign bus.inst_addr_o     = rst ? 32'd0 : w_addr;
  assign bus.preif_addr_ok_o = w_accept & ~bus.flush_i & ~r_flush_pend & ~rst;
  assign bus.if_ready_go_o   = w_ready_go & ~rst;
  assign bus.if_inst_o       = rst ? '0 : (r_buf_valid ? r_buf_data : bus.inst_rdata_i);
  assign bus.outst_cnt_o     = rst ? 2'd0 : r_outst;

  //--------------------------------------------------------------------------
  // Counter must never wrap in either direction
  //--------------------------------------------------------------------------
  a_outst_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_accept && !bus.inst_data_ok_i && (r_outst == C_MAX_OUTST)));

  a_outst_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(bus.inst_data_ok_i && !w_accept && (r_outst == 2'd0)));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctl.sv
//==============================================================================
// Module   : tb_if_fetch_ctl
// Brief    : Directed self-checking bench for if_fetch_ctl
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_fetch_ctl;

  localparam int DATA_W = 64;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  if_fetch_ctl_if #(.DATA_W(DATA_W)) bus ();

  if_fetch_ctl #(
    .MAX_OUTST (2),
    .DATA_W    (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.preif_req_i    = 1'b0;
    bus.preif_pc_i     = 32'd0;
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b0;
    bus.inst_rdata_i   = '0;
    bus.if_valid_i     = 1'b1;
    bus.if_no_req_i    = 1'b0;
    bus.id_allowin_i   = 1'b1;
    bus.flush_i        = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic aok);
    idle_in();
    bus.preif_req_i    = 1'b1;
    bus.preif_pc_i     = pc;
    bus.inst_addr_ok_i = aok;
  endtask

  task automatic data(input logic [63:0] d);
    idle_in();
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   64'(bus.inst_req_o),      64'd0);
    chk({tag, "_addr"},  64'(bus.inst_addr_o),     64'd0);
    chk({tag, "_aok"},   64'(bus.preif_addr_ok_o), 64'd0);
    chk({tag, "_rg"},    64'(bus.if_ready_go_o),   64'd0);
    chk({tag, "_inst"},  bus.if_inst_o,            64'd0);
    chk({tag, "_cnt"},   64'(bus.outst_cnt_o),     64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with active-looking inputs: outputs must still read zero
    rst = 1'b1;
    fetch(32'h1C00_0000, 1'b1);
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.if_no_req_i    = 1'b1;
    #2;
    chk_zero("rst0");
    tick();
    chk_zero("rst1");

    // Scenario 1: immediate accept, data two cycles later
    rst = 1'b0;
    fetch(32'h1C00_0000, 1'b1);
    #1;
    chk("s1_req",  64'(bus.inst_req_o), 64'd1);
    chk("s1_addr", 64'(bus.inst_addr_o), 64'h1C00_0000);
    chk("s1_aok",  64'(bus.preif_addr_ok_o), 64'd1);
    chk("s1_cnt0", 64'(bus.outst_cnt_o), 64'd0);
    tick(); idle_in(); #1;
    chk("s1_cnt1", 64'(bus.outst_cnt_o), 64'd1);
    chk("s1_rg0",  64'(bus.if_ready_go_o), 64'd0);
    tick(); data(64'h1111_0001_2222_0001); #1;
    chk("s1_rg",   64'(bus.if_ready_go_o), 64'd1);
    chk("s1_inst", bus.if_inst_o, 64'h1111_0001_2222_0001);
    tick(); idle_in(); #1;
    chk("s1_cnt2", 64'(bus.outst_cnt_o), 64'd0);
    chk("s1_rg1",  64'(bus.if_ready_go_o), 64'd0);

    // Scenario 2: accept delayed three cycles, PC changes meanwhile
    tick(); fetch(32'h1C00_0000, 1'b0); #1;
    chk("s2_req",  64'(bus.inst_req_o), 64'd1);
    chk("s2_aok0", 64'(bus.preif_addr_ok_o), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); fetch(32'h1C00_0008, 1'b0); #1;
      chk("s2_hold_addr", 64'(bus.inst_addr_o), 64'h1C00_0000);
      chk("s2_hold_aok",  64'(bus.preif_addr_ok_o), 64'd0);
    end
    tick(); fetch(32'h1C00_0008, 1'b1); #1;
    chk("s2_acc_addr", 64'(bus.inst_addr_o), 64'h1C00_0000);
    chk("s2_acc_aok",  64'(bus.preif_addr_ok_o), 64'd1);
    tick(); idle_in(); #1;
    chk("s2_req_off", 64'(bus.inst_req_o), 64'd0);
    chk("s2_cnt1",    64'(bus.outst_cnt_o), 64'd1);
    tick(); data(64'h3333_0002_4444_0002); #1;
    chk("s2_rg",   64'(bus.if_ready_go_o), 64'd1);
    chk("s2_inst", bus.if_inst_o, 64'h3333_0002_4444_0002);
    tick(); idle_in(); #1;
    chk("s2_cnt0", 64'(bus.outst_cnt_o), 64'd0);

    // Scenario 3: two in flight, flush, both responses dropped
    tick(); fetch(32'h1C00_0010, 1'b1); #1;
    chk("s3_aok_a", 64'(bus.preif_addr_ok_o), 64'd1);
    tick(); fetch(32'h1C00_0018, 1'b1); #1;
    chk("s3_aok_b", 64'(bus.preif_addr_ok_o), 64'd1);
    chk("s3_cnt1",  64'(bus.outst_cnt_o), 64'd1);
    tick(); fetch(32'h1C00_0020, 1'b0); #1;
    chk("s3_cnt2",  64'(bus.outst_cnt_o), 64'd2);
    chk("s3_limit", 64'(bus.inst_req_o), 64'd0);
    tick(); idle_in(); bus.flush_i = 1'b1; #1;
    chk("s3_flush_rg", 64'(bus.if_ready_go_o), 64'd0);
    tick(); data(64'hEEEE_0001_EEEE_0001); #1;
    chk("s3_drop1", 64'(bus.if_ready_go_o), 64'd0);
    tick(); data(64'hEEEE_0002_EEEE_0002); #1;
    chk("s3_drop2", 64'(bus.if_ready_go_o), 64'd0);
    chk("s3_cnt_d", 64'(bus.outst_cnt_o), 64'd1);
    tick(); fetch(32'h1C00_0030, 1'b1); #1;
    chk("s3_cnt0", 64'(bus.outst_cnt_o), 64'd0);
    chk("s3_aok_c", 64'(bus.preif_addr_ok_o), 64'd1);
    tick(); data(64'hEEEE_0003_EEEE_0003); #1;
    chk("s3_rg",   64'(bus.if_ready_go_o), 64'd1);
    chk("s3_inst", bus.if_inst_o, 64'hEEEE_0003_EEEE_0003);

    // Scenario 4: next stage stalls for four cycles, data parked in buffer
    tick(); fetch(32'h1C00_0040, 1'b1); #1;
    chk("s4_aok", 64'(bus.preif_addr_ok_o), 64'd1);
    tick(); data(64'hF0F0_0001_0F0F_0001); bus.id_allowin_i = 1'b0; #1;
    chk("s4_rg0",   64'(bus.if_ready_go_o), 64'd1);
    chk("s4_inst0", bus.if_inst_o, 64'hF0F0_0001_0F0F_0001);
    for (int i = 0; i < 3; i++) begin
      tick(); fetch(32'h1C00_0048, 1'b0);
      bus.id_allowin_i = 1'b0;
      bus.inst_rdata_i = 64'h0000_0BAD_0000_0BAD;
      #1;
      chk("s4_buf_rg",   64'(bus.if_ready_go_o), 64'd1);
      chk("s4_buf_inst", bus.if_inst_o, 64'hF0F0_0001_0F0F_0001);
      chk("s4_no_req",   64'(bus.inst_req_o), 64'd0);
    end
    tick(); fetch(32'h1C00_0048, 1'b0); bus.inst_rdata_i = 64'h0000_0BAD_0000_0BAD; #1;
    chk("s4_hand_rg",   64'(bus.if_ready_go_o), 64'd1);
    chk("s4_hand_inst", bus.if_inst_o, 64'hF0F0_0001_0F0F_0001);
    chk("s4_hand_req",  64'(bus.inst_req_o), 64'd0);
    tick(); fetch(32'h1C00_0048, 1'b1); #1;
    chk("s4_free_req", 64'(bus.inst_req_o), 64'd1);
    chk("s4_free_rg",  64'(bus.if_ready_go_o), 64'd0);
    tick(); data(64'hF0F0_0002_0F0F_0002); #1;
    chk("s4_inst2", bus.if_inst_o, 64'hF0F0_0002_0F0F_0002);
    chk("s4_rg2",   64'(bus.if_ready_go_o), 64'd1);

    // Scenario 5: flush while holding, late accept is dropped
    tick(); fetch(32'h1C00_0050, 1'b0); #1;
    chk("s5_req", 64'(bus.inst_req_o), 64'd1);
    tick(); idle_in(); bus.flush_i = 1'b1; #1;
    chk("s5_fl_req",  64'(bus.inst_req_o), 64'd1);
    chk("s5_fl_addr", 64'(bus.inst_addr_o), 64'h1C00_0050);
    tick(); idle_in(); #1;
    chk("s5_addr", 64'(bus.inst_addr_o), 64'h1C00_0050);
    tick(); idle_in(); bus.inst_addr_ok_i = 1'b1; #1;
    chk("s5_aok",     64'(bus.preif_addr_ok_o), 64'd0);
    chk("s5_acc_req", 64'(bus.inst_req_o), 64'd1);
    tick(); idle_in(); #1;
    chk("s5_cnt1", 64'(bus.outst_cnt_o), 64'd1);
    tick(); data(64'h6666_0001_6666_0001); #1;
    chk("s5_drop", 64'(bus.if_ready_go_o), 64'd0);
    tick(); fetch(32'h1C00_0060, 1'b1); #1;
    chk("s5_aok2", 64'(bus.preif_addr_ok_o), 64'd1);
    tick(); data(64'h6666_0002_6666_0002); #1;
    chk("s5_rg2",   64'(bus.if_ready_go_o), 64'd1);
    chk("s5_inst2", bus.if_inst_o, 64'h6666_0002_6666_0002);

    // Fetch-exception path needs no data, and flush still suppresses it
    tick(); idle_in(); bus.if_no_req_i = 1'b1; #1;
    chk("nr_rg", 64'(bus.if_ready_go_o), 64'd1);
    bus.flush_i = 1'b1; #1;
    chk("nr_flush_rg", 64'(bus.if_ready_go_o), 64'd0);

    // Scenario 6: asynchronous reset mid-HOLD with one outstanding
    tick(); fetch(32'h1C00_0070, 1'b1); #1;
    chk("s6_aok", 64'(bus.preif_addr_ok_o), 64'd1);
    tick(); fetch(32'h1C00_0078, 1'b0); #1;
    chk("s6_hold_addr", 64'(bus.inst_addr_o), 64'h1C00_0078);
    chk("s6_cnt1",      64'(bus.outst_cnt_o), 64'd1);
    #2;
    rst = 1'b1;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 64'h7777_0000_7777_0000;
    #1;
    chk_zero("s6_rst");
    tick(); #1;
    chk_zero("s6_rst_hold");
    rst = 1'b0;
    fetch(32'h1C00_0080, 1'b1); #1;
    chk("s6_req",  64'(bus.inst_req_o), 64'd1);
    chk("s6_addr", 64'(bus.inst_addr_o), 64'h1C00_0080);
    chk("s6_aok2", 64'(bus.preif_addr_ok_o), 64'd1);
    chk("s6_cnt0", 64'(bus.outst_cnt_o), 64'd0);
    tick(); data(64'h7777_0001_7777_0001); #1;
    chk("s6_rg",   64'(bus.if_ready_go_o), 64'd1);
    chk("s6_inst", bus.if_inst_o, 64'h7777_0001_7777_0001);
    chk("s6_cnt",  64'(bus.outst_cnt_o), 64'd1);
    tick(); idle_in(); #1;
    chk("s6_cnt_end", 64'(bus.outst_cnt_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_ctl.md
IF_FETCH_CTL -- requirements
Module: if_fetch_ctl

Interface
REQ-001 Parameter MAX_OUTST, default 2, SHALL set the maximum number of accepted fetch requests still waiting for data (range 1..3).
REQ-002 Parameter DATA_W, default 64, SHALL set the fetch data width (two 32-bit instructions).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 preif_req_i  in  1  SHALL indicate that preIF has a valid PC to fetch.
REQ-006 preif_pc_i  in  32  SHALL carry the fetch PC.
REQ-007 preif_addr_ok_o  out  1  SHALL pulse when the request is accepted; preIF advances on this pulse.
REQ-008 inst_req_o  out  1  SHALL be the instruction-memory request.
REQ-009 inst_addr_o  out  32  SHALL be the request address.
REQ-010 inst_addr_ok_i  in  1  SHALL indicate that memory accepted the request.
REQ-011 inst_data_ok_i  in  1  SHALL indicate that response data is valid this cycle.
REQ-012 inst_rdata_i  in  DATA_W  SHALL carry the response data.
REQ-013 if_valid_i  in  1  SHALL indicate that the IF stage holds an instruction.
REQ-014 if_no_req_i  in  1  SHALL indicate that the IF instruction issued no request (fetch exception).
REQ-015 id_allowin_i  in  1  SHALL indicate that the next stage allows input.
REQ-016 flush_i  in  1  SHALL be the exception or branch flush.
REQ-017 if_ready_go_o  out  1  SHALL indicate that IF data is available.
REQ-018 if_inst_o  out  DATA_W  SHALL carry the IF instruction data.
REQ-019 outst_cnt_o  out  2  SHALL report the outstanding-request count.

Function
REQ-020 The request FSM SHALL use two states: IDLE and HOLD.
REQ-021 The IDLE -> issue condition SHALL be: IDLE & preif_req_i & ~flush_i & outst_cnt < MAX_OUTST & ~buf_valid; when true, inst_req_o=1 and inst_addr_o=preif_pc_i.
REQ-022 Issue without inst_addr_ok_i SHALL go to HOLD and latch the address.
REQ-023 In HOLD, inst_req_o=1 and inst_addr_o SHALL equal the latched address, unchanged until inst_addr_ok_i, regardless of flush_i.
REQ-024 On inst_addr_ok_i, HOLD SHALL return to IDLE.
REQ-025 preif_addr_ok_o SHALL equal inst_req_o & inst_addr_ok_i & ~flush_i & ~flush_pend; flush_pend is set by a flush while in HOLD and cleared on that addr_ok.
REQ-026 outst_cnt SHALL be updated as outst_cnt + (inst_req_o & inst_addr_ok_i) - inst_data_ok_i; simultaneous accept and data SHALL leave it unchanged.
REQ-027 outst_cnt SHALL saturate at neither end: overflow and underflow are assertion failures.
REQ-028 On flush_i, discard_cnt SHALL load outst_cnt - inst_data_ok_i + (inst_req_o & inst_addr_ok_i).
REQ-029 While discard_cnt > 0, each inst_data_ok_i SHALL decrement discard_cnt, and that data SHALL be dropped (not buffered, no ready_go).
REQ-030 A HOLD request accepted after a flush SHALL be counted into discard_cnt at acceptance.
REQ-031 Zero-latency path: if_ready_go_o SHALL equal if_valid_i & (if_no_req_i | buf_valid | (inst_data_ok_i & discard_cnt==0)) & ~flush_i.
REQ-032 if_inst_o SHALL equal buf_data when buf_valid, else inst_rdata_i.
REQ-033 Buffering SHALL occur when accepted data (discard_cnt==0) arrives while ~(if_valid_i & id_allowin_i): buf_valid<=1 and buf_data<=inst_rdata_i.
REQ-034 buf_valid SHALL clear on if_valid_i & id_allowin_i & if_ready_go_o, or on flush_i; flush SHALL take priority over a same-cycle buffer write.
REQ-035 No new request SHALL issue while buf_valid=1 (at most one unconsumed fetch beyond the buffer).

Reset
REQ-036 During rst=1, the FSM SHALL be in IDLE, with outst_cnt=0, discard_cnt=0, buf_valid=0, flush_pend=0, buf_data=0, and the latched address 0.
REQ-037 During rst=1, outputs SHALL be: inst_req_o=0, inst_addr_o=0, preif_addr_ok_o=0, if_ready_go_o=0, if_inst_o=0, outst_cnt_o=0.
REQ-038 Reset SHALL be asynchronous, effective immediately, and SHALL abandon any HOLD or pending discards.
REQ-039 After rst is released, the first issue SHALL be possible on the first rising edge.

Verification
REQ-040 Scenario 1: preif_req_i=1, pc=0x1C000000, addr_ok same cycle, data_ok (0x...) 2 cycles later, id_allowin=1 -> addr_ok_o pulse, outst 1 then 0, ready_go for exactly 1 cycle with the data.
REQ-041 Scenario 2: addr_ok delayed 3 cycles, pc changes to 0x1C000008 during the wait -> inst_addr_o stays 0x1C000000 in HOLD; a single addr_ok_o pulse.
REQ-042 Scenario 3: two requests accepted (outst=2), flush_i for 1 cycle -> discard_cnt=2; next two data_ok dropped, no ready_go; the third request's data is delivered.
REQ-043 Scenario 4: data_ok arrives with id_allowin=0 for 4 cycles -> buf_valid=1, ready_go held, no new inst_req_o; when allowin=1, handoff occurs and buf_valid=0 next cycle.
REQ-044 Scenario 5: flush in HOLD, addr_ok 2 cycles later -> addr_ok_o=0, discard_cnt=1, and the response is dropped.
REQ-045 Scenario 6: rst asserted mid-HOLD with outst=1 -> all outputs 0 immediately; a subsequent fetch runs normally.
